// File: rtl/otter_csr_intr.sv
// ----------------------------------------------------------------------------
// otter_csr_intr
//   Machine-mode CSR file and external-interrupt controller for the Otter core.
//   It synchronizes the asynchronous interrupt pin and detects its rising edge.
//   It holds the request as a pending flag until the core may take it, and then
//   enters the trap. It also executes the csrrw and mret requests from the
//   decoder.
//
// Ports
//   clk           in   core clock; all state updates on the rising edge
//   rst_n         in   asynchronous active-low reset
//   intrpt_in     in   external interrupt level (asynchronous); a rising edge
//                      raises a request
//   instr_commit  in   single-cycle pulse; the current instruction retires
//   pc_next       in   address of the next instruction; saved to mepc on a trap
//   csr_we        in   csrrw executing (qualified by instr_commit)
//   csr_addr      in   CSR address for the csrrw and for csr_rdata
//   csr_wdata     in   rs1 value written by csrrw
//   mret_exec     in   mret executing (qualified by instr_commit)
//   csr_rdata     out  combinational read of csr_addr (pre-write value)
//   mtvec         out  trap vector for the PC mux
//   mepc          out  trap return address for the PC mux
//   intrpt_taken  out  a trap is entered this cycle (combinational)
//   intrpt_pend   out  registered pending-request flag
// ----------------------------------------------------------------------------
module otter_csr_intr #(
   parameter int                XLEN        = 32,
   parameter int                SYNC_STAGES = 2,
   parameter logic [XLEN-1:0]   RESET_MTVEC = {XLEN{1'b0}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              intrpt_in,
   input  logic              instr_commit,
   input  logic [XLEN-1:0]   pc_next,
   input  logic              csr_we,
   input  logic [11:0]       csr_addr,
   input  logic [XLEN-1:0]   csr_wdata,
   input  logic              mret_exec,
   output logic [XLEN-1:0]   csr_rdata,
   output logic [XLEN-1:0]   mtvec,
   output logic [XLEN-1:0]   mepc,
   output logic              intrpt_taken,
   output logic              intrpt_pend
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MIE     = 12'h304;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

   // Interrupt flag set, cause code 11 = machine external interrupt.
   localparam logic [XLEN-1:0] MCAUSE_MEXT = {1'b1, {(XLEN-5){1'b0}}, 4'hB};

   // Clears the low two bits. mtvec and mepc are always word-aligned.
   function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] v);
      return {v[XLEN-1:2], 2'b00};
   endfunction

   logic [SYNC_STAGES-1:0] sync_q,   sync_d;
   logic                   prev_q,   prev_d;
   logic                   pend_q,   pend_d;
   logic                   mie_q,    mie_d;     // mstatus.MIE  (bit 3)
   logic                   mpie_q,   mpie_d;    // mstatus.MPIE (bit 7)
   logic                   meie_q,   meie_d;    // mie.MEIE     (bit 11)
   logic [XLEN-1:0]        mtvec_q,  mtvec_d;
   logic [XLEN-1:0]        mepc_q,   mepc_d;
   logic [XLEN-1:0]        mcause_q, mcause_d;

   logic                   edge_s;
   logic                   take_s;
   logic                   csr_wr_s;
   logic                   mret_s;

   // Edge detect on the synchronized level, and the trap-entry qualifier.
   always_comb begin
      edge_s   = sync_q[SYNC_STAGES-1] & ~prev_q;
      take_s   = instr_commit & pend_q & mie_q & meie_q;
      // A trap entry suppresses the instruction's own CSR side effects.
      csr_wr_s = instr_commit & csr_we    & ~take_s;
      mret_s   = instr_commit & mret_exec & ~take_s;
   end

   // Next-state logic for the synchronizer, the pending flag and all CSRs.
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], intrpt_in};
      prev_d   = sync_q[SYNC_STAGES-1];
      // A new edge in the take cycle re-arms pending (the edge wins).
      pend_d   = edge_s | (pend_q & ~take_s);
      mie_d    = mie_q;
      mpie_d   = mpie_q;
      meie_d   = meie_q;
      mtvec_d  = mtvec_q;
      mepc_d   = mepc_q;
      mcause_d = mcause_q;

      if (take_s) begin
         mepc_d   = align4(pc_next);
         mcause_d = MCAUSE_MEXT;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end else if (mret_s) begin
         mie_d    = mpie_q;
         mpie_d   = 1'b1;
      end else if (csr_wr_s) begin
         case (csr_addr)
            ADDR_MSTATUS: begin
               mie_d  = csr_wdata[3];
               mpie_d = csr_wdata[7];
            end
            ADDR_MIE:    meie_d  = csr_wdata[11];
            ADDR_MTVEC:  mtvec_d = align4(csr_wdata);
            ADDR_MEPC:   mepc_d  = align4(csr_wdata);
            default:     mcause_d = mcause_q;   // mcause is read-only; unknown addresses are ignored
         endcase
      end else begin
         mcause_d = mcause_q;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= {SYNC_STAGES{1'b0}};
         prev_q   <= 1'b0;
         pend_q   <= 1'b0;
         mie_q    <= 1'b0;
         mpie_q   <= 1'b0;
         meie_q   <= 1'b0;
         mtvec_q  <= align4(RESET_MTVEC);
         mepc_q   <= {XLEN{1'b0}};
         mcause_q <= {XLEN{1'b0}};
      end else begin
         sync_q   <= sync_d;
         prev_q   <= prev_d;
         pend_q   <= pend_d;
         mie_q    <= mie_d;
         mpie_q   <= mpie_d;
         meie_q   <= meie_d;
         mtvec_q  <= mtvec_d;
         mepc_q   <= mepc_d;
         mcause_q <= mcause_d;
      end
   end

   // CSR read mux; unimplemented bits and addresses read as zero.
   always_comb begin
      case (csr_addr)
         ADDR_MSTATUS: csr_rdata = {{(XLEN-8){1'b0}}, mpie_q, 3'b000, mie_q, 3'b000};
         ADDR_MIE:     csr_rdata = {{(XLEN-12){1'b0}}, meie_q, 11'h000};
         ADDR_MTVEC:   csr_rdata = mtvec_q;
         ADDR_MEPC:    csr_rdata = mepc_q;
         ADDR_MCAUSE:  csr_rdata = mcause_q;
         default:      csr_rdata = {XLEN{1'b0}};
      endcase
   end

   assign mtvec        = mtvec_q;
   assign mepc         = mepc_q;
   assign intrpt_taken = take_s;
   assign intrpt_pend  = pend_q;

endmodule

// File: tb/tb_otter_csr_intr.sv
`timescale 1ns/1ps
// Testbench for otter_csr_intr.
// It keeps an architectural model of the CSRs and of the interrupt latency.
// A compare process checks the DUT against the model at every negedge.
// Directed literal checks pin the model to hand-computed values.
module tb_otter_csr_intr;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        intrpt_in;
   logic        instr_commit;
   logic [31:0] pc_next;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic        mret_exec;
   logic [31:0] csr_rdata;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic        intrpt_taken;
   logic        intrpt_pend;

   int vectors = 0;
   int errs    = 0;
   bit chk_en  = 1'b0;

   otter_csr_intr #(.XLEN(32), .SYNC_STAGES(2), .RESET_MTVEC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .intrpt_in(intrpt_in), .instr_commit(instr_commit),
      .pc_next(pc_next), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .mret_exec(mret_exec), .csr_rdata(csr_rdata), .mtvec(mtvec), .mepc(mepc),
      .intrpt_taken(intrpt_taken), .intrpt_pend(intrpt_pend)
   );

   always #5 clk = ~clk;

   // ---------------- architectural model ----------------
   logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause;
   logic        m_pend;
   // This holds the pin level sampled at the last three clock edges; bit 0 is
   // the newest. With two sync stages the controller sees a rise one edge
   // after bit 1 first shows it, where bit 2 still shows the old level.
   logic [2:0]  m_hist;

   task automatic model_reset();
      m_mstatus = 32'h0; m_mie = 32'h0; m_mtvec = 32'h0;
      m_mepc = 32'h0; m_mcause = 32'h0; m_pend = 1'b0; m_hist = 3'b000;
   endtask

   function automatic logic m_take();
      return instr_commit & m_pend & m_mstatus[3] & m_mie[11];
   endfunction

   function automatic logic [31:0] m_rdata(input logic [11:0] a);
      case (a)
         12'h300: return m_mstatus;
         12'h304: return m_mie;
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         default: return 32'h0;
      endcase
   endfunction

   // This applies one clock edge to the model, using the inputs held during the ending cycle.
   task automatic model_step();
      logic edge_now;
      logic take;
      if (rst_n) begin
         edge_now = m_hist[1] & ~m_hist[2];
         take = m_take();
         if (take) begin
            m_mepc    = pc_next & 32'hFFFF_FFFC;
            m_mcause  = 32'h8000_000B;
            m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
            m_pend    = edge_now;
         end else begin
            m_pend = m_pend | edge_now;
            if (instr_commit && csr_we) begin
               case (csr_addr)
                  12'h300: m_mstatus = csr_wdata & 32'h88;
                  12'h304: m_mie     = csr_wdata & 32'h800;
                  12'h305: m_mtvec   = csr_wdata & 32'hFFFF_FFFC;
                  12'h341: m_mepc    = csr_wdata & 32'hFFFF_FFFC;
                  default: ;
               endcase
            end else if (instr_commit && mret_exec) begin
               m_mstatus = (m_mstatus[7] ? 32'h08 : 32'h0) | 32'h80;
            end
         end
         m_hist = {m_hist[1:0], intrpt_in};
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         vectors++;
         if (csr_rdata !== m_rdata(csr_addr)) begin
            errs++; $display("FAIL rdata t=%0t addr=%h got %h exp %h", $time, csr_addr, csr_rdata, m_rdata(csr_addr));
         end
         if (mtvec !== m_mtvec) begin
            errs++; $display("FAIL mtvec t=%0t got %h exp %h", $time, mtvec, m_mtvec);
         end
         if (mepc !== m_mepc) begin
            errs++; $display("FAIL mepc t=%0t got %h exp %h", $time, mepc, m_mepc);
         end
         if (intrpt_taken !== m_take()) begin
            errs++; $display("FAIL taken t=%0t got %b exp %b", $time, intrpt_taken, m_take());
         end
         if (intrpt_pend !== m_pend) begin
            errs++; $display("FAIL pend t=%0t got %b exp %b", $time, intrpt_pend, m_pend);
         end
      end
   end

   task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s t=%0t got %h exp %h", name, $time, act, exp);
      end
   endtask

   // One cycle: the model updates at the edge, then the next inputs are driven 2 ns later.
   task automatic cyc(input logic c, input logic we, input logic [11:0] a,
                      input logic [31:0] wd, input logic mr, input logic [31:0] pc);
      @(posedge clk);
      model_step();
      #2;
      instr_commit = c; csr_we = we; csr_addr = a; csr_wdata = wd; mret_exec = mr; pc_next = pc;
      #2;
   endtask

   logic        r_c, r_we, r_mr;
   logic [11:0] r_a;
   logic [31:0] r_wd;
   int unsigned r_op;

   initial begin
      rst_n = 1'b1; intrpt_in = 1'b0; instr_commit = 1'b0; pc_next = 32'h0;
      csr_we = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0; mret_exec = 1'b0;
      model_reset();
      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      #1;
      check_lit("rst_mtvec", mtvec, 32'h0);
      check_lit("rst_mepc", mepc, 32'h0);
      check_lit("rst_taken", {31'h0, intrpt_taken}, 32'h0);
      cyc(1'b1, 1'b0, 12'h300, 32'h0, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 12'h300, 32'h0, 1'b0, 32'h0);
      rst_n = 1'b1;

      // csrrw to mtvec: the read returns the old value and the low bits are forced to 0
      cyc(1'b1, 1'b1, 12'h305, 32'h0000_1003, 1'b0, 32'h100);
      check_lit("mtvec_old", csr_rdata, 32'h0);
      cyc(1'b0, 1'b0, 12'h305, 32'h0, 1'b0, 32'h0);
      check_lit("mtvec_new", csr_rdata, 32'h0000_1000);
      check_lit("mtvec_out", mtvec, 32'h0000_1000);

      // enable, then a rise is taken on the third commit cycle
      cyc(1'b1, 1'b1, 12'h300, 32'h8, 1'b0, 32'h40);
      cyc(1'b1, 1'b1, 12'h304, 32'h800, 1'b0, 32'h40);
      cyc(1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h40);
      intrpt_in = 1'b1;
      cyc(1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h40);
      check_lit("t3_c1", {31'h0, intrpt_taken}, 32'h0);
      cyc(1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h40);
      check_lit("t3_c2", {31'h0, intrpt_taken}, 32'h0);
      cyc(1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h40);
      check_lit("t3_take", {31'h0, intrpt_taken}, 32'h1);
      check_lit("t3_pend", {31'h0, intrpt_pend}, 32'h1);
      cyc(1'b0, 1'b0, 12'h342, 32'h0, 1'b0, 32'h0);
      check_lit("mcause", csr_rdata, 32'h8000_000B);
      check_lit("mepc40", mepc, 32'h40);
      cyc(1'b0, 1'b0, 12'h300, 32'h0, 1'b0, 32'h0);
      check_lit("mstat80", csr_rdata, 32'h80);

      // mret restores MIE; a held level does not retrigger
      cyc(1'b1, 1'b0, 12'h000, 32'h0, 1'b1, 32'h44);
      cyc(1'b0, 1'b0, 12'h300, 32'h0, 1'b0, 32'h0);
      check_lit("mstat88", csr_rdata, 32'h88);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h48);
         check_lit("held_notake", {31'h0, intrpt_taken}, 32'h0);
      end

      // edge with MIE=0 stays pending; enabling MIE takes it at the next commit
      cyc(1'b1, 1'b1, 12'h300, 32'h0, 1'b0, 32'h50);
      check_lit("mstat_old88", csr_rdata, 32'h88);
      intrpt_in = 1'b0;
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h50);
      intrpt_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h50);
         check_lit("mie0_notake", {31'h0, intrpt_taken}, 32'h0);
      end
      check_lit("mie0_pend", {31'h0, intrpt_pend}, 32'h1);
      cyc(1'b1, 1'b1, 12'h300, 32'h8, 1'b0, 32'h80);
      check_lit("wr_cycle_notake", {31'h0, intrpt_taken}, 32'h0);
      cyc(1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h80);
      check_lit("t5_take", {31'h0, intrpt_taken}, 32'h1);
      cyc(1'b0, 1'b0, 12'h341, 32'h0, 1'b0, 32'h0);
      check_lit("mepc80", csr_rdata, 32'h80);

      // a take in the same cycle as a csrrw to mie suppresses the write
      intrpt_in = 1'b0;
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 12'h000, 32'h0, 1'b1, 32'h0);
      intrpt_in = 1'b1;
      cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0);
      cyc(1'b1, 1'b1, 12'h304, 32'h0, 1'b0, 32'hC4);
      check_lit("t6_take", {31'h0, intrpt_taken}, 32'h1);
      cyc(1'b0, 1'b0, 12'h304, 32'h0, 1'b0, 32'h0);
      check_lit("mie_kept", csr_rdata, 32'h800);
      cyc(1'b0, 1'b0, 12'h7C0, 32'h0, 1'b0, 32'h0);
      check_lit("unimpl_rd", csr_rdata, 32'h0);
      check_lit("mepcC4", mepc, 32'hC4);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r_op = $urandom_range(0, 9);
         r_c  = ($urandom_range(0, 3) != 0);
         r_we = 1'b0; r_mr = 1'b0;
         r_wd = $urandom;
         case ($urandom_range(0, 6))
            0:       r_a = 12'h300;
            1:       r_a = 12'h304;
            2:       r_a = 12'h305;
            3:       r_a = 12'h341;
            4:       r_a = 12'h342;
            5:       r_a = 12'($urandom);
            default: r_a = 12'h300;
         endcase
         if (r_a == 12'h300 && $urandom_range(0, 3) != 0) r_wd[3] = 1'b1;
         if (r_a == 12'h304 && $urandom_range(0, 3) != 0) r_wd[11] = 1'b1;
         if (r_op >= 4 && r_op <= 6) r_we = 1'b1;
         if (r_op == 7) r_mr = 1'b1;
         if (r_op == 8) begin r_c = 1'b0; r_we = 1'b1; end
         if (r_op == 9) begin r_c = 1'b0; r_mr = 1'b1; end
         cyc(r_c, r_we, r_a, r_wd, r_mr, $urandom);
         if ($urandom_range(0, 7) == 0) intrpt_in = ~intrpt_in;
      end

      // mid-cycle reset clears state at once and drops any pending request
      cyc(1'b1, 1'b0, 12'h000, 32'h0, 1'b1, 32'h0);
      cyc(1'b1, 1'b1, 12'h305, 32'h0000_1234, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 12'h305, 32'h0, 1'b0, 32'h0);
      check_lit("pre_rst_mtvec", mtvec, 32'h0000_1234);
      rst_n = 1'b0;
      model_reset();
      #0.5;
      check_lit("mid_rst_mtvec", mtvec, 32'h0);
      check_lit("mid_rst_mepc", mepc, 32'h0);
      check_lit("mid_rst_taken", {31'h0, intrpt_taken}, 32'h0);
      check_lit("mid_rst_pend", {31'h0, intrpt_pend}, 32'h0);
      cyc(1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 12'h300, 32'h0, 1'b0, 32'h0);

      @(posedge clk);
      #2 chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
